// File: rtl/div_bcd_pkg.sv
// Shared types and helpers for the DIV quotient to BCD converter.
package div_bcd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DABBLE = 3'd2,
        FRAC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Smallest d with 10^d > 2^int_w; 30103/100000 approximates log10(2).
    function automatic int min_int_dig(input int int_w);
        return (int_w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/div_bcd_conv.sv
// Fixed-point quotient to packed BCD, one bit/digit per cycle.
// Define DIV_BCD_LZ_BLANK_EN to blank leading integer zeros in DONE.
module div_bcd_conv
    import div_bcd_pkg::*;
#(
    parameter int SIZE     = 96,
    parameter int DEC_SIZE = 32,
    parameter int INT_DIG  = 20,
    parameter int FRAC_DIG = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [SIZE-1:0]       quo,
    output logic [4*INT_DIG-1:0]  bcd_int,
    output logic [4*FRAC_DIG-1:0] bcd_frac,
    output logic                  busy,
    output logic                  out_valid
);

    localparam int INT_W   = SIZE - DEC_SIZE;
    localparam int CNT_MAX = (INT_W > FRAC_DIG) ? INT_W : FRAC_DIG;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INT_LAST  = CW'(INT_W - 1);
    localparam logic [CW-1:0] FRAC_LAST = CW'(FRAC_DIG - 1);

    generate
        if (INT_DIG < min_int_dig(INT_W)) begin : g_chk
            $error("INT_DIG too small for integer width");
        end
    endgenerate

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [INT_W-1:0]        int_sr;
    logic [DEC_SIZE-1:0]     frac_sr;
    logic [4*INT_DIG-1:0]    acc;
    logic [4*INT_DIG-1:0]    adj;
    logic [4*FRAC_DIG-1:0]   fdig;
    logic [4*INT_DIG-1:0]    bcd_int_r;
    logic [4*FRAC_DIG-1:0]   bcd_frac_r;
    logic [DEC_SIZE+3:0]     prod;
    logic [3:0]              digit;

    generate
        for (genvar g = 0; g < INT_DIG; g++) begin : g_add3
            bcd_add3 u_add3 (
                .d (acc[4*g +: 4]),
                .q (adj[4*g +: 4])
            );
        end
    endgenerate

    assign prod  = ({4'b0, frac_sr} << 3) + ({4'b0, frac_sr} << 1);
    assign digit = prod[DEC_SIZE+3:DEC_SIZE];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:   if (in_valid) state_nxt = LOAD;
            LOAD: begin
                busy      = 1'b1;
                state_nxt = DABBLE;
            end
            DABBLE: begin
                busy = 1'b1;
                if (cnt == INT_LAST) state_nxt = FRAC;
            end
            FRAC: begin
                busy = 1'b1;
                if (cnt == FRAC_LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (!in_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            int_sr     <= '0;
            frac_sr    <= '0;
            acc        <= '0;
            fdig       <= '0;
            bcd_int_r  <= '0;
            bcd_frac_r <= '0;
        end else begin
            case (state)
                LOAD: begin
                    int_sr     <= quo[SIZE-1:DEC_SIZE];
                    frac_sr    <= quo[DEC_SIZE-1:0];
                    acc        <= '0;
                    cnt        <= '0;
                    fdig       <= '0;
                    bcd_int_r  <= '0;
                    bcd_frac_r <= '0;
                end
                DABBLE: begin
                    {acc, int_sr} <= {adj, int_sr} << 1;
                    cnt <= (cnt == INT_LAST) ? '0 : cnt + CW'(1);
                end
                FRAC: begin
                    frac_sr <= prod[DEC_SIZE-1:0];
                    fdig    <= {fdig[4*FRAC_DIG-5:0], digit};
                    cnt     <= cnt + CW'(1);
                    // Last digit goes straight into the held result.
                    if (cnt == FRAC_LAST) begin
                        bcd_int_r  <= acc;
                        bcd_frac_r <= {fdig[4*FRAC_DIG-5:0], digit};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd_frac = bcd_frac_r;

`ifdef DIV_BCD_LZ_BLANK_EN
    logic lead;
    always_comb begin
        bcd_int = bcd_int_r;
        lead    = 1'b1;
        if (state == DONE) begin
            for (int i = INT_DIG - 1; i > 0; i--) begin
                if (lead && bcd_int_r[4*i +: 4] == 4'h0)
                    bcd_int[4*i +: 4] = BCD_BLANK;
                else
                    lead = 1'b0;
            end
        end
    end
`else
    assign bcd_int = bcd_int_r;
`endif

endmodule

// File: tb/tb_div_bcd_conv.sv
// Randomized scoreboard bench for div_bcd_conv against an arithmetic model.
module tb_div_bcd_conv;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [95:0] quo;
    logic [79:0] bcd_int;
    logic [15:0] bcd_frac;
    logic        busy;
    logic        out_valid;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [79:0] i;
        logic [15:0] f;
    } exp_t;

    exp_t sbq[$];
    logic ov_q = 1'b0;

    div_bcd_conv dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .quo       (quo),
        .bcd_int   (bcd_int),
        .bcd_frac  (bcd_frac),
        .busy      (busy),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] ref_int(input logic [95:0] q);
        logic [63:0] v;
        logic [79:0] r;
        bit          lead;
        v = q[95:32];
        r = '0;
        for (int k = 0; k < 20; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
`ifdef DIV_BCD_LZ_BLANK_EN
        lead = 1'b1;
        for (int k = 19; k > 0; k--) begin
            if (lead && r[4*k +: 4] == 4'h0) r[4*k +: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        return r;
    endfunction

    // Four truncated decimal places = floor(frac * 10^4 / 2^32).
    function automatic logic [15:0] ref_frac(input logic [95:0] q);
        logic [63:0] s;
        logic [15:0] r;
        s = ({32'b0, q[31:0]} * 64'd10000) >> 32;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (out_valid && !ov_q) begin
            if (sbq.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("bcd_int", bcd_int, e.i);
                check("bcd_frac", bcd_frac, e.f);
            end
        end
        ov_q <= out_valid;
    end

    task automatic convert(input logic [95:0] q, input int hold,
                           input bit drop_early);
        @(negedge clk);
        quo      = q;
        in_valid = 1'b1;
        sbq.push_back('{i: ref_int(q), f: ref_frac(q)});
        @(posedge clk); #1;
        if (drop_early) in_valid = 1'b0;
        @(posedge clk); #1;
        quo = {$urandom, $urandom, $urandom};
        repeat (67) @(posedge clk);
        #1;
        check("pre_latency_valid", out_valid, 0);
        check("pre_latency_busy", busy, 1);
        @(posedge clk); #1;
        check("latency_valid", out_valid, 1);
        check("done_busy", busy, 0);
        if (drop_early) begin
            @(posedge clk); #1;
            check("one_cycle_valid", out_valid, 0);
        end else begin
            repeat (hold) begin
                @(posedge clk); #1;
                check("held_valid", out_valid, 1);
            end
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk); #1;
            check("release_valid", out_valid, 0);
        end
    endtask

    initial begin
        logic [95:0] q;
        reset    = 1'b1;
        in_valid = 1'b0;
        quo      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_int", bcd_int, 0);
        check("rst_frac", bcd_frac, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;

        convert({64'd7, 32'h8000_0000}, 0, 1'b0);
        convert({64'd0, 32'h5555_5555}, 2, 1'b0);
        convert({64'hFFFF_FFFF_FFFF_FFFF, 32'h0}, 1, 1'b0);
        q = (96'd22 << 32) / 96'd7;
        convert(q, 5, 1'b0);
        convert({64'd305, 32'h0000_1234}, 0, 1'b1);
        convert({64'd0, 32'h0}, 1, 1'b0);

        for (int n = 0; n < 12; n++) begin
            q = {$urandom, $urandom, $urandom};
            if (n % 3 == 0) q[95:64] = '0;
            if (n % 4 == 1) q[95:48] = '0;
            convert(q, $urandom_range(0, 3), 1'(($urandom % 2)));
        end

        // Abort mid-DABBLE, then restart from the held request.
        @(negedge clk);
        quo      = {64'd123456789, 32'hC000_0000};
        in_valid = 1'b1;
        @(posedge clk);
        repeat (31) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_int", bcd_int, 0);
        check("abort_frac", bcd_frac, 0);
        @(negedge clk);
        reset = 1'b0;
        sbq.push_back('{i: ref_int(quo), f: ref_frac(quo)});
        @(posedge clk);
        repeat (68) @(posedge clk);
        #1;
        check("restart_pre_valid", out_valid, 0);
        @(posedge clk); #1;
        check("restart_valid", out_valid, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
